alarm_scheduler: RTL and testbench

Alarm controller that sits beside the 24-hour wall clock and sequences an alarm resource. It holds an alarm setpoint in BCD and arms/disarms it. It watches the running clock time for a match, then drives a ringing output through ring, snooze and timeout phases. Setpoint edits use the same debounced minute/hour increment buttons as the clock, gated by a set-mode input.

---
 rtl/alarm_pkg.sv | 28 ++
 rtl/bcd_time_inc.sv | 47 ++++
 rtl/alarm_scheduler.sv | 178 +++++++++++++++++
 tb/tb_alarm_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: state encodings and BCD field limits.
package alarm_pkg;

  localparam logic [2:0] ST_DISABLED = 3'd0;
  localparam logic [2:0] ST_ARMED    = 3'd1;
  localparam logic [2:0] ST_RINGING  = 3'd2;
  localparam logic [2:0] ST_SNOOZED  = 3'd3;
  localparam logic [2:0] ST_SET      = 3'd4;

  typedef enum logic [2:0] {
    S_DISABLED = ST_DISABLED,
    S_ARMED    = ST_ARMED,
    S_RINGING  = ST_RINGING,
    S_SNOOZED  = ST_SNOOZED,
    S_SET      = ST_SET
  } state_t;

  localparam logic [3:0] MIN_TENS_MAX   = 4'd5;
  localparam logic [3:0] MIN_ONES_MAX   = 4'd9;
  localparam logic [3:0] HR_TENS_MAX    = 4'd2;
  localparam logic [3:0] HR_ONES_MAX_24 = 4'd3;

  // Ones digit of the hour never exceeds 9 except in the last decade, where it stops at 3.
  function automatic logic hour_at_max(input logic [3:0] h2, input logic [3:0] h1);
    return (h2 == HR_TENS_MAX) && (h1 == HR_ONES_MAX_24);
  endfunction

endpackage

// File: rtl/bcd_time_inc.sv
// Combinational next value for a BCD HH:MM time; minute and hour increments are
// independent (no carry from minutes into hours) and hours wrap 23 -> 00.
module bcd_time_inc
  import alarm_pkg::*;
(
  input  logic [3:0] hours2,
  input  logic [3:0] hours1,
  input  logic [3:0] mins2,
  input  logic [3:0] mins1,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [3:0] hours2_next,
  output logic [3:0] hours1_next,
  output logic [3:0] mins2_next,
  output logic [3:0] mins1_next
);

  always_comb begin
    mins2_next = mins2;
    mins1_next = mins1;
    if (inc_min) begin
      if (mins1 == MIN_ONES_MAX) begin
        mins1_next = 4'd0;
        mins2_next = (mins2 == MIN_TENS_MAX) ? 4'd0 : mins2 + 4'd1;
      end else begin
        mins1_next = mins1 + 4'd1;
      end
    end
  end

  always_comb begin
    hours2_next = hours2;
    hours1_next = hours1;
    if (inc_hour) begin
      if (hour_at_max(hours2, hours1)) begin
        hours2_next = 4'd0;
        hours1_next = 4'd0;
      end else if (hours1 == MIN_ONES_MAX) begin
        hours1_next = 4'd0;
        hours2_next = hours2 + 4'd1;
      end else begin
        hours1_next = hours1 + 4'd1;
      end
    end
  end

endmodule

// File: rtl/alarm_scheduler.sv
// Alarm controller beside the wall clock: holds a BCD setpoint, detects minute
// events matching it and sequences ring / snooze / timeout phases.
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MINS       = 5,
  parameter int RING_TIMEOUT_MINS = 10
) (
  input  logic       CLK100MHZ,
  input  logic       RESET_BTN,
  input  logic [3:0] hours2,
  input  logic [3:0] hours1,
  input  logic [3:0] mins2,
  input  logic [3:0] mins1,
  input  logic       SET_ALARM,
  input  logic       INC_MIN,
  input  logic       INC_HOUR,
  input  logic       ALARM_EN,
  input  logic       SNOOZE,
  input  logic       STOP,
  output logic [3:0] al_hours2,
  output logic [3:0] al_hours1,
  output logic [3:0] al_mins2,
  output logic [3:0] al_mins1,
  output logic       show_alarm,
  output logic       armed,
  output logic       ringing,
  output logic [2:0] state
);

  localparam logic [4:0] SNOOZE_LIM = 5'(SNOOZE_MINS);
  localparam logic [4:0] RING_LIM   = 5'(RING_TIMEOUT_MINS);

  // Button order: 0 INC_MIN, 1 INC_HOUR, 2 SNOOZE, 3 STOP
  logic [3:0] btn_lvl;
  logic [3:0] btn_prev_reg;
  logic [3:0] btn_rise;

  assign btn_lvl = {STOP, SNOOZE, INC_HOUR, INC_MIN};

  always_ff @(posedge CLK100MHZ) begin
    if (RESET_BTN) btn_prev_reg <= 4'd0;
    else           btn_prev_reg <= btn_lvl;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_edge
      assign btn_rise[gi] = btn_lvl[gi] & ~btn_prev_reg[gi];
    end
  endgenerate

  logic [15:0] time_now;
  logic [15:0] time_reg;
  logic [15:0] setpoint;
  logic        tick;
  logic        match;

  assign time_now = {hours2, hours1, mins2, mins1};

  // The copy also loads during reset so the first cycle afterwards sees no tick.
  always_ff @(posedge CLK100MHZ) begin
    time_reg <= time_now;
  end

  assign tick  = (time_now != time_reg);
  assign match = tick && (time_now == setpoint);

  state_t     state_reg, state_next;
  logic [3:0] ring_cnt_reg, ring_cnt_next;
  logic [3:0] snz_cnt_reg, snz_cnt_next;
  logic [3:0] al_h2_reg, al_h1_reg, al_m2_reg, al_m1_reg;
  logic [3:0] al_h2_next, al_h1_next, al_m2_next, al_m1_next;
  logic       in_set;
  logic       show_alarm_reg, armed_reg, ringing_reg;

  assign setpoint = {al_h2_reg, al_h1_reg, al_m2_reg, al_m1_reg};
  assign in_set   = SET_ALARM && (state_reg == S_SET);

  bcd_time_inc u_setpoint_inc (
    .hours2      (al_h2_reg),
    .hours1      (al_h1_reg),
    .mins2       (al_m2_reg),
    .mins1       (al_m1_reg),
    .inc_min     (btn_rise[0] & in_set),
    .inc_hour    (btn_rise[1] & in_set),
    .hours2_next (al_h2_next),
    .hours1_next (al_h1_next),
    .mins2_next  (al_m2_next),
    .mins1_next  (al_m1_next)
  );

  always_comb begin
    state_next    = state_reg;
    ring_cnt_next = ring_cnt_reg;
    snz_cnt_next  = snz_cnt_reg;
    if (SET_ALARM) begin
      state_next = S_SET;
    end else if (state_reg == S_SET) begin
      state_next = ALARM_EN ? S_ARMED : S_DISABLED;
    end else if (!ALARM_EN) begin
      state_next    = S_DISABLED;
      ring_cnt_next = 4'd0;
      snz_cnt_next  = 4'd0;
    end else begin
      case (state_reg)
        S_DISABLED: state_next = S_ARMED;
        S_ARMED: begin
          if (match) begin
            state_next    = S_RINGING;
            ring_cnt_next = 4'd0;
          end
        end
        S_RINGING: begin
          if (btn_rise[3]) begin
            state_next = S_ARMED;
          end else if (btn_rise[2]) begin
            state_next   = S_SNOOZED;
            snz_cnt_next = 4'd0;
          end else if (tick) begin
            if ({1'b0, ring_cnt_reg} + 5'd1 == RING_LIM) state_next = S_ARMED;
            else ring_cnt_next = ring_cnt_reg + 4'd1;
          end
        end
        S_SNOOZED: begin
          if (btn_rise[3]) begin
            state_next = S_ARMED;
          end else if (tick) begin
            if ({1'b0, snz_cnt_reg} + 5'd1 == SNOOZE_LIM) begin
              state_next    = S_RINGING;
              ring_cnt_next = 4'd0;
            end else begin
              snz_cnt_next = snz_cnt_reg + 4'd1;
            end
          end
        end
        default: state_next = S_DISABLED;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RESET_BTN) begin
      state_reg      <= S_DISABLED;
      ring_cnt_reg   <= 4'd0;
      snz_cnt_reg    <= 4'd0;
      al_h2_reg      <= 4'd0;
      al_h1_reg      <= 4'd0;
      al_m2_reg      <= 4'd0;
      al_m1_reg      <= 4'd0;
      show_alarm_reg <= 1'b0;
      armed_reg      <= 1'b0;
      ringing_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ring_cnt_reg   <= ring_cnt_next;
      snz_cnt_reg    <= snz_cnt_next;
      al_h2_reg      <= al_h2_next;
      al_h1_reg      <= al_h1_next;
      al_m2_reg      <= al_m2_next;
      al_m1_reg      <= al_m1_next;
      show_alarm_reg <= (state_next == S_SET);
      armed_reg      <= (state_next == S_ARMED) || (state_next == S_RINGING) ||
                        (state_next == S_SNOOZED);
      ringing_reg    <= (state_next == S_RINGING);
    end
  end

  assign al_hours2  = al_h2_reg;
  assign al_hours1  = al_h1_reg;
  assign al_mins2   = al_m2_reg;
  assign al_mins1   = al_m1_reg;
  assign show_alarm = show_alarm_reg;
  assign armed      = armed_reg;
  assign ringing    = ringing_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed self-checking bench for alarm_scheduler: setpoint entry, wrap, match,
// snooze, timeout, priority and reset behaviour.
module tb_alarm_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] hours2, hours1, mins2, mins1;
  logic       set_alarm, inc_min, inc_hour, alarm_en, snooze, stop;
  logic [3:0] al_hours2, al_hours1, al_mins2, al_mins1;
  logic       show_alarm, armed, ringing;
  logic [2:0] state;

  int checks_total  = 0;
  int checks_failed = 0;

  localparam logic [2:0] DIS = 3'd0, ARM = 3'd1, RNG = 3'd2, SNZ = 3'd3, SETS = 3'd4;

  alarm_scheduler #(.SNOOZE_MINS(5), .RING_TIMEOUT_MINS(10)) dut (
    .CLK100MHZ (clk),
    .RESET_BTN (rst),
    .hours2    (hours2),
    .hours1    (hours1),
    .mins2     (mins2),
    .mins1     (mins1),
    .SET_ALARM (set_alarm),
    .INC_MIN   (inc_min),
    .INC_HOUR  (inc_hour),
    .ALARM_EN  (alarm_en),
    .SNOOZE    (snooze),
    .STOP      (stop),
    .al_hours2 (al_hours2),
    .al_hours1 (al_hours1),
    .al_mins2  (al_mins2),
    .al_mins1  (al_mins1),
    .show_alarm(show_alarm),
    .armed     (armed),
    .ringing   (ringing),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_total++;
    assert (obs === exp)
    else begin
      checks_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_time(input logic [15:0] t);
    {hours2, hours1, mins2, mins1} = t;
  endtask

  task automatic press_min(input int n);
    for (int i = 0; i < n; i++) begin
      inc_min = 1'b1; step();
      inc_min = 1'b0; step();
    end
  endtask

  task automatic press_hour(input int n);
    for (int i = 0; i < n; i++) begin
      inc_hour = 1'b1; step();
      inc_hour = 1'b0; step();
    end
  endtask

  task automatic press_both(input int n);
    for (int i = 0; i < n; i++) begin
      inc_min = 1'b1; inc_hour = 1'b1; step();
      inc_min = 1'b0; inc_hour = 1'b0; step();
    end
  endtask

  // Walk 07:29 -> 07:30 to trigger a fresh match against a 07:30 setpoint.
  task automatic ring_now();
    set_time(16'h0729); step();
    set_time(16'h0730); step();
  endtask

  function automatic logic [15:0] sp();
    return {al_hours2, al_hours1, al_mins2, al_mins1};
  endfunction

  initial begin
    rst = 1'b1; set_alarm = 0; inc_min = 0; inc_hour = 0;
    alarm_en = 0; snooze = 0; stop = 0;
    set_time(16'h1200);
    step(2);
    rst = 1'b0;
    step();
    check("reset_state", 16'(state), 16'(DIS));
    check("reset_setpoint", sp(), 16'h0000);
    check("reset_outputs", {13'd0, show_alarm, armed, ringing}, 16'd0);

    // Setpoint entry 07:30
    set_alarm = 1; alarm_en = 1; step();
    check("set_enter_state", 16'(state), 16'(SETS));
    check("set_show", 16'(show_alarm), 16'd1);
    press_hour(7);
    press_min(30);
    check("set_value", sp(), 16'h0730);
    check("set_show_hold", 16'(show_alarm), 16'd1);
    set_alarm = 0; step();
    check("set_exit_state", 16'(state), 16'(ARM));
    check("set_exit_flags", {13'd0, show_alarm, armed, ringing}, 16'b010);

    // SNOOZE and STOP ignored while merely ARMED
    snooze = 1; stop = 1; step();
    snooze = 0; stop = 0; step();
    check("armed_ignore_btns", 16'(state), 16'(ARM));

    // Match timing
    set_time(16'h0729); step();
    check("premtach_no_ring", 16'(ringing), 16'd0);
    set_time(16'h0730);
    check("match_before_edge", 16'(ringing), 16'd0);
    step();
    check("match_ring", 16'(ringing), 16'd1);
    check("match_state", 16'(state), 16'(RNG));

    stop = 1; step();
    check("stop_state", 16'(state), 16'(ARM));
    check("stop_ring", 16'(ringing), 16'd0);
    stop = 0; step(5);
    check("hold_no_rering", 16'(ringing), 16'd0);

    // Snooze 5 minutes
    ring_now();
    check("ring2", 16'(ringing), 16'd1);
    snooze = 1; step();
    snooze = 0;
    check("snooze_state", 16'(state), 16'(SNZ));
    check("snooze_ring_off", 16'(ringing), 16'd0);
    set_time(16'h0731); step();
    set_time(16'h0732); step();
    set_time(16'h0733); step();
    set_time(16'h0734); step();
    check("snooze_0734", 16'(state), 16'(SNZ));
    set_time(16'h0735); step();
    check("snooze_rering_0735", 16'(ringing), 16'd1);
    check("snooze_rering_state", 16'(state), 16'(RNG));

    // Timeout after 10 ticks (07:36 .. 07:45)
    set_time(16'h0736); step();
    set_time(16'h0737); step();
    set_time(16'h0738); step();
    set_time(16'h0739); step();
    set_time(16'h0740); step();
    set_time(16'h0741); step();
    set_time(16'h0742); step();
    set_time(16'h0743); step();
    set_time(16'h0744); step();
    check("timeout_9th_tick", 16'(ringing), 16'd1);
    set_time(16'h0745); step();
    check("timeout_10th_tick", 16'(state), 16'(ARM));
    check("timeout_flags", {13'd0, show_alarm, armed, ringing}, 16'b010);

    // STOP and SNOOZE together: STOP wins
    ring_now();
    check("ring3", 16'(state), 16'(RNG));
    stop = 1; snooze = 1; step();
    stop = 0; snooze = 0;
    check("stop_over_snooze", 16'(state), 16'(ARM));

    // ALARM_EN drop while ringing
    step();
    ring_now();
    alarm_en = 0; step();
    check("en_drop_state", 16'(state), 16'(DIS));
    check("en_drop_flags", {13'd0, show_alarm, armed, ringing}, 16'b000);
    alarm_en = 1; step();
    check("en_rearm", 16'(state), 16'(ARM));

    // SET entered while ringing exits to ARMED without re-ring
    ring_now();
    set_alarm = 1; step();
    check("set_over_ring", 16'(ringing), 16'd0);
    set_alarm = 0; step();
    check("set_exit_armed", 16'(state), 16'(ARM));
    step(3);
    check("set_exit_no_ring", 16'(ringing), 16'd0);

    // Reset mid-SNOOZED
    ring_now();
    snooze = 1; step();
    snooze = 0;
    check("pre_reset_snz", 16'(state), 16'(SNZ));
    rst = 1; step();
    rst = 0;
    check("reset_mid_state", 16'(state), 16'(DIS));
    check("reset_mid_setpoint", sp(), 16'h0000);
    check("reset_mid_outputs", {13'd0, show_alarm, armed, ringing}, 16'd0);

    // Wrap: 23:59 then simultaneous minute+hour edge -> 00:00
    set_alarm = 1; step();
    press_both(23);
    press_min(36);
    check("wrap_pre", sp(), 16'h2359);
    press_both(1);
    check("wrap_post", sp(), 16'h0000);
    set_alarm = 0; alarm_en = 0; step();
    check("wrap_exit_disabled", 16'(state), 16'(DIS));

    $display("%0d/%0d checks passed", checks_total - checks_failed, checks_total);
    $finish;
  end

endmodule
